idct_pass_sequencer: RTL and testbench

Controller for a two-pass 8x8 inverse DCT built from the 8-tap systolic IDCT row elements. It accepts a block start, issues eight column vectors (pass 1), waits for the pipeline to drain into the transpose buffer, then issues eight row vectors (pass 2). It drives the per-pass `shift`/`add` rounding configuration and tags every result leaving the datapath with its pass and vector index. It sits between the coefficient source and transpose buffer on one side and the bank of IDCT row elements on the other.

---
 rtl/idct_pass_sequencer_if.sv | 35 +++
 rtl/idct_pass_sequencer.sv | 141 ++++++++++++++
 tb/tb_idct_pass_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/idct_pass_sequencer_if.sv
// Bundle between the two-pass IDCT sequencer and its surroundings.
//   start, src_ready           : block request and pass-1 coefficient availability
//   busy, done                 : block status
//   dp_valid/pass/idx          : vector issued to the row-element datapath
//   dp_shift, dp_add           : final-stage rounding for the current pass
//   res_valid/pass/idx         : tag of the result leaving the datapath
// slave is the sequencer side; master is the block that drives start/src_ready.
interface idct_pass_sequencer_if;
  logic        start;
  logic        src_ready;
  logic        busy;
  logic        done;
  logic        dp_valid;
  logic        dp_pass;
  logic [2:0]  dp_idx;
  logic [3:0]  dp_shift;
  logic [24:0] dp_add;
  logic        res_valid;
  logic        res_pass;
  logic [2:0]  res_idx;

  modport slave (
    input  start, src_ready,
    output busy, done,
    output dp_valid, dp_pass, dp_idx, dp_shift, dp_add,
    output res_valid, res_pass, res_idx
  );

  modport master (
    output start, src_ready,
    input  busy, done,
    input  dp_valid, dp_pass, dp_idx, dp_shift, dp_add,
    input  res_valid, res_pass, res_idx
  );
endinterface

// File: rtl/idct_pass_sequencer.sv
// Two-pass 8x8 IDCT controller. Issues eight column vectors (pass 1, gated by
// src_ready), waits for the datapath to drain, issues eight row vectors
// (pass 2), then pulses done. A LAT-deep tracking line tags every result.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : idct_pass_sequencer_if.slave (start/src_ready in, status, issue and
//           result tags out)
module idct_pass_sequencer #(
  parameter int unsigned LAT       = 9,
  parameter int unsigned BIT_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  idct_pass_sequencer_if.slave bus
);

  localparam int unsigned IDX_W   = 3;
  localparam int unsigned SHIFT_W = 4;
  localparam int unsigned ADD_W   = 25;
  localparam int unsigned S1      = 7;
  localparam int unsigned ADD1    = 64;
  localparam int unsigned S2      = 20 - BIT_DEPTH;
  localparam int unsigned ADD2    = 1 << (S2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(7);

  typedef enum logic [2:0] {
    IDLE, PASS1, DRAIN1, PASS2, DRAIN2, DONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             pass;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_t               state;
  logic [IDX_W-1:0]     count;
  logic                 pass_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic [ADD_W-1:0]     add_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 issue;
  logic                 drained;
  tag_t                 line [LAT];

  // Issue is combinational on src_ready so a bubble costs exactly one cycle.
  assign issue = ((state == PASS1) && bus.src_ready) || (state == PASS2);

  // Every stage but the tail is empty: the last result is on res_* now (or
  // already gone), so the next cycle may switch rounding safely.
  always_comb begin
    drained = 1'b1;
    for (int unsigned i = 0; i < LAT - 1; i++) begin
      if (line[i].valid) drained = 1'b0;
    end
  end

  // Tracking line: mirrors the datapath latency, bubbles included.
  always_ff @(posedge clk) begin
    if (!reset) begin
      line <= '{default: '0};
    end else begin
      line[0] <= '{valid: issue, pass: pass_q, idx: count};
      for (int unsigned i = 1; i < LAT; i++) begin
        line[i] <= line[i-1];
      end
    end
  end

  // Pass sequencing, issue counter and rounding configuration.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      pass_q  <= 1'b0;
      shift_q <= '0;
      add_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= PASS1;
            count   <= '0;
            pass_q  <= 1'b0;
            shift_q <= SHIFT_W'(S1);
            add_q   <= ADD_W'(ADD1);
            busy_q  <= 1'b1;
          end
        end
        PASS1: begin
          if (bus.src_ready) begin
            count <= count + 1'b1;
            if (count == LAST_IDX) state <= DRAIN1;
          end
        end
        DRAIN1: begin
          if (drained) begin
            state   <= PASS2;
            count   <= '0;
            pass_q  <= 1'b1;
            shift_q <= SHIFT_W'(S2);
            add_q   <= ADD_W'(ADD2);
          end
        end
        PASS2: begin
          count <= count + 1'b1;
          if (count == LAST_IDX) state <= DRAIN2;
        end
        DRAIN2: begin
          if (drained) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          // start is ignored here; the next accept happens in IDLE.
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dp_valid  = issue;
  assign bus.dp_pass   = pass_q;
  assign bus.dp_idx    = count;
  assign bus.dp_shift  = shift_q;
  assign bus.dp_add    = add_q;
  assign bus.res_valid = line[LAT-1].valid;
  assign bus.res_pass  = line[LAT-1].pass;
  assign bus.res_idx   = line[LAT-1].idx;

endmodule

// File: tb/tb_idct_pass_sequencer.sv
// Bench for idct_pass_sequencer: three instances (defaults, BIT_DEPTH=10,
// LAT=2). Expected issue/result/done events are queued from the timing rules
// when a block is started and checked by a negedge monitor.
module tb_idct_pass_sequencer;

  typedef struct {
    int          cyc;
    logic        pass;
    logic [2:0]  idx;
    logic [3:0]  shift;
    logic [24:0] add;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   t0;

  ev_t iss_q [3][$];
  ev_t res_q [3][$];
  int  done_q [3][$];

  idct_pass_sequencer_if ia ();
  idct_pass_sequencer_if ib ();
  idct_pass_sequencer_if ic ();

  idct_pass_sequencer #(.LAT(9), .BIT_DEPTH(8))  dut_a (.clk(clk), .reset(reset), .bus(ia));
  idct_pass_sequencer #(.LAT(9), .BIT_DEPTH(10)) dut_b (.clk(clk), .reset(reset), .bus(ib));
  idct_pass_sequencer #(.LAT(2), .BIT_DEPTH(8))  dut_c (.clk(clk), .reset(reset), .bus(ic));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(int d, string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL dut%0d %s: observed %0d expected %0d", d, tag, obs, exp);
    end
  endtask

  task automatic at_cyc(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected events of one block started at cycle t0; a gap of g cycles
  // before pass-1 index gi; events after cycle upto are not expected.
  task automatic push_block(int d, int t0, int lat, int s2, int gi, int g, int upto);
    ev_t e;
    int  c;
    for (int k = 0; k < 8; k++) begin
      c = t0 + 1 + k + ((k >= gi) ? g : 0);
      e.pass = 1'b0; e.idx = 3'(k); e.shift = 4'd7; e.add = 25'd64;
      if (c <= upto) begin e.cyc = c; iss_q[d].push_back(e); end
      if (c + lat <= upto) begin e.cyc = c + lat; res_q[d].push_back(e); end
    end
    for (int k = 0; k < 8; k++) begin
      c = t0 + 9 + lat + g + k;
      e.pass = 1'b1; e.idx = 3'(k); e.shift = 4'(s2); e.add = 25'(1 << (s2 - 1));
      if (c <= upto) begin e.cyc = c; iss_q[d].push_back(e); end
      if (c + lat <= upto) begin e.cyc = c + lat; res_q[d].push_back(e); end
    end
    c = t0 + 17 + 2 * lat + g;
    if (c <= upto) done_q[d].push_back(c);
  endtask

  task automatic mon(int d, logic dv, logic dpp, logic [2:0] di, logic [3:0] ds,
                     logic [24:0] da, logic rv, logic rp, logic [2:0] ri, logic dn);
    ev_t e;
    int  c;
    while (iss_q[d].size() > 0 && iss_q[d][0].cyc < cyc) begin
      e = iss_q[d].pop_front();
      chk(d, "missed_issue_cycle", 32'(cyc), 32'(e.cyc));
    end
    while (res_q[d].size() > 0 && res_q[d][0].cyc < cyc) begin
      e = res_q[d].pop_front();
      chk(d, "missed_result_cycle", 32'(cyc), 32'(e.cyc));
    end
    while (done_q[d].size() > 0 && done_q[d][0] < cyc) begin
      c = done_q[d].pop_front();
      chk(d, "missed_done_cycle", 32'(cyc), 32'(c));
    end
    if (dv === 1'b1) begin
      if (iss_q[d].size() == 0) chk(d, "unexpected_issue", 32'(dv), 32'(0));
      else if (iss_q[d][0].cyc != cyc) chk(d, "early_issue_cycle", 32'(cyc), 32'(iss_q[d][0].cyc));
      else begin
        e = iss_q[d].pop_front();
        chk(d, "issue_pass",  32'(dpp), 32'(e.pass));
        chk(d, "issue_idx",   32'(di),  32'(e.idx));
        chk(d, "issue_shift", 32'(ds),  32'(e.shift));
        chk(d, "issue_add",   32'(da),  32'(e.add));
      end
    end
    if (rv === 1'b1) begin
      if (res_q[d].size() == 0) chk(d, "unexpected_result", 32'(rv), 32'(0));
      else if (res_q[d][0].cyc != cyc) chk(d, "early_result_cycle", 32'(cyc), 32'(res_q[d][0].cyc));
      else begin
        e = res_q[d].pop_front();
        chk(d, "result_pass", 32'(rp), 32'(e.pass));
        chk(d, "result_idx",  32'(ri), 32'(e.idx));
      end
    end
    if (dn === 1'b1) begin
      if (done_q[d].size() == 0) chk(d, "unexpected_done", 32'(dn), 32'(0));
      else begin
        c = done_q[d].pop_front();
        chk(d, "done_cycle", 32'(cyc), 32'(c));
      end
    end
  endtask

  task automatic chk_zero(int d, logic dv, logic dpp, logic [2:0] di, logic [3:0] ds,
                          logic [24:0] da, logic rv, logic rp, logic [2:0] ri,
                          logic dn, logic bz);
    chk(d, "rst_dp_valid",  32'(dv),  32'(0));
    chk(d, "rst_dp_pass",   32'(dpp), 32'(0));
    chk(d, "rst_dp_idx",    32'(di),  32'(0));
    chk(d, "rst_dp_shift",  32'(ds),  32'(0));
    chk(d, "rst_dp_add",    32'(da),  32'(0));
    chk(d, "rst_res_valid", 32'(rv),  32'(0));
    chk(d, "rst_res_pass",  32'(rp),  32'(0));
    chk(d, "rst_res_idx",   32'(ri),  32'(0));
    chk(d, "rst_done",      32'(dn),  32'(0));
    chk(d, "rst_busy",      32'(bz),  32'(0));
  endtask

  task automatic leftover(int d);
    chk(d, "leftover_issues",  32'(iss_q[d].size()),  32'(0));
    chk(d, "leftover_results", 32'(res_q[d].size()),  32'(0));
    chk(d, "leftover_done",    32'(done_q[d].size()), 32'(0));
  endtask

  always @(negedge clk) begin
    mon(0, ia.dp_valid, ia.dp_pass, ia.dp_idx, ia.dp_shift, ia.dp_add,
        ia.res_valid, ia.res_pass, ia.res_idx, ia.done);
    mon(1, ib.dp_valid, ib.dp_pass, ib.dp_idx, ib.dp_shift, ib.dp_add,
        ib.res_valid, ib.res_pass, ib.res_idx, ib.done);
    mon(2, ic.dp_valid, ic.dp_pass, ic.dp_idx, ic.dp_shift, ic.dp_add,
        ic.res_valid, ic.res_pass, ic.res_idx, ic.done);
  end

  initial begin
    reset = 1'b0;
    ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
    ia.src_ready = 1'b1; ib.src_ready = 1'b1; ic.src_ready = 1'b1;

    // Reset state on all instances.
    at_cyc(2);
    chk_zero(0, ia.dp_valid, ia.dp_pass, ia.dp_idx, ia.dp_shift, ia.dp_add,
             ia.res_valid, ia.res_pass, ia.res_idx, ia.done, ia.busy);
    chk_zero(1, ib.dp_valid, ib.dp_pass, ib.dp_idx, ib.dp_shift, ib.dp_add,
             ib.res_valid, ib.res_pass, ib.res_idx, ib.done, ib.busy);
    chk_zero(2, ic.dp_valid, ic.dp_pass, ic.dp_idx, ic.dp_shift, ic.dp_add,
             ic.res_valid, ic.res_pass, ic.res_idx, ic.done, ic.busy);
    reset = 1'b1;

    // One block on each instance: defaults, BIT_DEPTH=10, LAT=2.
    t0 = 5;
    at_cyc(t0);
    push_block(0, t0, 9, 12, 8, 0, 1 << 30);
    push_block(1, t0, 9, 10, 8, 0, 1 << 30);
    push_block(2, t0, 2, 12, 8, 0, 1 << 30);
    ia.start = 1'b1; ib.start = 1'b1; ic.start = 1'b1;
    at_cyc(t0 + 1);
    ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
    chk(0, "busy_after_accept", 32'(ia.busy), 32'(1));
    at_cyc(t0 + 36);
    chk(0, "busy_idle",        32'(ia.busy),     32'(0));
    chk(0, "idle_keeps_shift", 32'(ia.dp_shift), 32'(12));
    chk(0, "idle_keeps_add",   32'(ia.dp_add),   32'(2048));
    chk(1, "idle_keeps_shift", 32'(ib.dp_shift), 32'(10));
    chk(1, "idle_keeps_add",   32'(ib.dp_add),   32'(512));
    at_cyc(t0 + 40);
    leftover(0); leftover(1); leftover(2);

    // src_ready bubble at cycles 3 and 4.
    t0 = 50;
    at_cyc(t0);
    push_block(0, t0, 9, 12, 2, 2, 1 << 30);
    ia.start = 1'b1;
    at_cyc(t0 + 1);
    ia.start = 1'b0;
    at_cyc(t0 + 3);
    ia.src_ready = 1'b0;
    at_cyc(t0 + 5);
    ia.src_ready = 1'b1;
    at_cyc(t0 + 42);
    leftover(0);

    // start held high: back-to-back blocks, next accept one cycle after done.
    t0 = 100;
    at_cyc(t0);
    push_block(0, t0, 9, 12, 8, 0, 1 << 30);
    push_block(0, t0 + 36, 9, 12, 8, 0, 1 << 30);
    ia.start = 1'b1;
    at_cyc(t0 + 20);
    chk(0, "busy_mid_block", 32'(ia.busy), 32'(1));
    at_cyc(t0 + 35);
    chk(0, "busy_in_done", 32'(ia.busy), 32'(1));
    at_cyc(t0 + 36);
    chk(0, "busy_idle_between", 32'(ia.busy), 32'(0));
    at_cyc(t0 + 37);
    chk(0, "busy_second_block", 32'(ia.busy), 32'(1));
    at_cyc(t0 + 71);
    ia.start = 1'b0;
    at_cyc(t0 + 76);
    leftover(0);

    // Reset in DRAIN1 discards in-flight results; a new block runs normally.
    t0 = 200;
    at_cyc(t0);
    push_block(0, t0, 9, 12, 8, 0, t0 + 12);
    ia.start = 1'b1;
    at_cyc(t0 + 1);
    ia.start = 1'b0;
    at_cyc(t0 + 12);
    reset = 1'b0;
    at_cyc(t0 + 13);
    chk_zero(0, ia.dp_valid, ia.dp_pass, ia.dp_idx, ia.dp_shift, ia.dp_add,
             ia.res_valid, ia.res_pass, ia.res_idx, ia.done, ia.busy);
    reset = 1'b1;
    at_cyc(t0 + 30);
    leftover(0);
    t0 = 240;
    at_cyc(t0);
    push_block(0, t0, 9, 12, 8, 0, 1 << 30);
    ia.start = 1'b1;
    at_cyc(t0 + 1);
    ia.start = 1'b0;
    at_cyc(t0 + 40);
    leftover(0); leftover(1); leftover(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
